// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared player state, hit flag, round codes and hitbox layout
package game_pkg;

    localparam logic [3:0] S_IDLE           = 4'd0;
    localparam logic [3:0] S_MOVEFORWARDS   = 4'd1;
    localparam logic [3:0] S_MOVEBACKWARDS  = 4'd2;
    localparam logic [3:0] S_B_ATTACK_START = 4'd3;
    localparam logic [3:0] S_B_ATTACK_END   = 4'd4;
    localparam logic [3:0] S_B_ATTACK_REST  = 4'd5;
    localparam logic [3:0] S_D_ATTACK_START = 4'd6;
    localparam logic [3:0] S_D_ATTACK_END   = 4'd7;
    localparam logic [3:0] S_D_ATTACK_REST  = 4'd8;
    localparam logic [3:0] S_HITSTUN        = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN      = 4'd10;

    localparam logic [1:0] HIT_NONE  = 2'b00;
    localparam logic [1:0] HIT_BASIC = 2'b01;
    localparam logic [1:0] HIT_DIR   = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        R_IDLE       = 3'd0,
        R_COUNTDOWN  = 3'd1,
        R_FIGHT      = 3'd2,
        R_KO         = 3'd3,
        R_MATCH_OVER = 3'd4
    } round_state_e;

    // Box packing: {basic_x1, basic_x2, dir_x1, dir_x2, hurt_x1, hurt_x2}, 10 bits each
    localparam int BOX_W        = 10;
    localparam int BASIC_X1_LSB = 50;
    localparam int BASIC_X2_LSB = 40;
    localparam int DIR_X1_LSB   = 30;
    localparam int DIR_X2_LSB   = 20;
    localparam int HURT_X1_LSB  = 10;
    localparam int HURT_X2_LSB  = 0;

    function automatic logic [9:0] box_field(input logic [59:0] box, input int lsb);
        return box[lsb +: BOX_W];
    endfunction

    function automatic logic x_overlap(input logic [9:0] a1, input logic [9:0] a2,
                                       input logic [9:0] d1, input logic [9:0] d2);
        return (a1 <= d2) && (d1 <= a2);
    endfunction

endpackage

// File: rtl/hit_detect.sv
// rtl/hit_detect.sv - attacker box vs defender hurt box, yields hitFlag candidate
module hit_detect
    import game_pkg::*;
(
    input  logic [3:0]  atk_state,
    input  logic [39:0] atk_box,
    input  logic [19:0] def_hurt,
    output logic [1:0]  hit
);

    logic [59:0] pair;
    assign pair = {atk_box, def_hurt};

    logic basic_ov, dir_ov;
    assign basic_ov = x_overlap(box_field(pair, BASIC_X1_LSB), box_field(pair, BASIC_X2_LSB),
                                box_field(pair, HURT_X1_LSB),  box_field(pair, HURT_X2_LSB));
    assign dir_ov   = x_overlap(box_field(pair, DIR_X1_LSB),   box_field(pair, DIR_X2_LSB),
                                box_field(pair, HURT_X1_LSB),  box_field(pair, HURT_X2_LSB));

    always_comb begin
        hit = HIT_NONE;
        if (atk_state == S_B_ATTACK_END && basic_ov)
            hit = HIT_BASIC;
        else if (atk_state == S_D_ATTACK_END && dir_ov)
            hit = HIT_DIR;
    end

endmodule

// File: rtl/combat_referee.sv
// rtl/combat_referee.sv - per-frame fight arbiter: hits, meters, round sequencing
module combat_referee
    import game_pkg::*;
#(
    parameter int HEALTH_MAX   = 5,
    parameter int BLOCK_MAX    = 3,
    parameter int BLOCK_REGEN  = 60,
    parameter int ROUND_FRAMES = 99 * 60,
    parameter int COUNTDOWN    = 180,
    parameter int KO_FRAMES    = 120,
    parameter int WINS_NEEDED  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  p1_state,
    input  logic [3:0]  p2_state,
    input  logic [59:0] p1_box,
    input  logic [59:0] p2_box,
    output logic [1:0]  p1_hit,
    output logic [1:0]  p2_hit,
    output logic [2:0]  p1_health,
    output logic [2:0]  p2_health,
    output logic [2:0]  p1_block,
    output logic [2:0]  p2_block,
    output logic [2:0]  round_state,
    output logic [12:0] frames_left,
    output logic [1:0]  p1_wins,
    output logic [1:0]  p2_wins,
    output logic [1:0]  winner,
    output logic        player_rst,
    output logic        input_en
);

    round_state_e rs;
    logic [7:0]   phase_cnt;
    logic [3:0]   st        [2];
    logic [1:0]   cand      [2];   // hit produced by attacker i
    logic [1:0]   incoming  [2];   // hit landing on defender i this frame
    logic [2:0]   dmg       [2];
    logic [2:0]   health    [2];
    logic [2:0]   block     [2];
    logic [7:0]   regen_cnt [2];
    logic [1:0]   hit_out   [2];
    logic [1:0]   wins      [2];
    logic         landed    [2];
    logic         match_won, round_over, enter_cd;
    logic [1:0]   round_winner;

    assign st[0] = p1_state;
    assign st[1] = p2_state;

    hit_detect u_p1_on_p2 (.atk_state(p1_state), .atk_box(p1_box[59:20]), .def_hurt(p2_box[19:0]), .hit(cand[0]));
    hit_detect u_p2_on_p1 (.atk_state(p2_state), .atk_box(p2_box[59:20]), .def_hurt(p1_box[19:0]), .hit(cand[1]));

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            incoming[d] = landed[1-d] ? HIT_NONE : cand[1-d];
            dmg[d]      = (incoming[d] == HIT_DIR) ? 3'd2 : 3'd1;
        end
    end

    assign match_won  = (wins[0] == 2'(WINS_NEEDED)) || (wins[1] == 2'(WINS_NEEDED));
    assign round_over = (health[0] == 3'd0) || (health[1] == 3'd0) || (frames_left == 13'd0);

    // Equal health covers both the double-KO and the tied-timeout draw.
    always_comb begin
        if (health[0] == health[1])     round_winner = WIN_DRAW;
        else if (health[0] > health[1]) round_winner = WIN_P1;
        else                            round_winner = WIN_P2;
    end

    always_comb begin
        enter_cd = 1'b0;
        case (rs)
            R_IDLE, R_MATCH_OVER: enter_cd = start;
            R_KO:                 enter_cd = (phase_cnt == 8'(KO_FRAMES - 1)) && !match_won;
            default:              enter_cd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs          <= R_IDLE;
            phase_cnt   <= '0;
            frames_left <= 13'(ROUND_FRAMES);
            winner      <= WIN_NONE;
            player_rst  <= 1'b0;
            input_en    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                health[i]    <= 3'(HEALTH_MAX);
                block[i]     <= 3'(BLOCK_MAX);
                regen_cnt[i] <= '0;
                hit_out[i]   <= HIT_NONE;
                wins[i]      <= '0;
                landed[i]    <= 1'b0;
            end
        end else begin
            player_rst <= 1'b0;
            for (int i = 0; i < 2; i++) hit_out[i] <= HIT_NONE;
            case (rs)
                R_COUNTDOWN: begin
                    if (phase_cnt == 8'(COUNTDOWN - 1)) begin
                        rs        <= R_FIGHT;
                        phase_cnt <= '0;
                        input_en  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                R_FIGHT: begin
                    if (round_over) begin
                        rs        <= R_KO;
                        phase_cnt <= '0;
                        input_en  <= 1'b0;
                        winner    <= round_winner;
                        if (round_winner == WIN_P1 && wins[0] != 2'd3) wins[0] <= wins[0] + 2'd1;
                        if (round_winner == WIN_P2 && wins[1] != 2'd3) wins[1] <= wins[1] + 2'd1;
                        for (int i = 0; i < 2; i++) landed[i] <= 1'b0;
                    end else begin
                        frames_left <= frames_left - 13'd1;
                        for (int i = 0; i < 2; i++) begin
                            hit_out[i] <= incoming[i];
                            landed[i]  <= (st[i] == S_B_ATTACK_END || st[i] == S_D_ATTACK_END) &&
                                          (landed[i] || cand[i] != HIT_NONE);
                            // Regen only accrues while not backing off, so it never races a block.
                            if (st[i] == S_MOVEBACKWARDS) begin
                                regen_cnt[i] <= '0;
                            end else if (regen_cnt[i] == 8'(BLOCK_REGEN - 1)) begin
                                regen_cnt[i] <= '0;
                                if (block[i] < 3'(BLOCK_MAX)) block[i] <= block[i] + 3'd1;
                            end else begin
                                regen_cnt[i] <= regen_cnt[i] + 8'd1;
                            end
                            if (incoming[i] != HIT_NONE) begin
                                if (st[i] == S_MOVEBACKWARDS && block[i] != 3'd0)
                                    block[i] <= block[i] - 3'd1;
                                else
                                    health[i] <= (health[i] > dmg[i]) ? health[i] - dmg[i] : 3'd0;
                            end
                        end
                    end
                end
                R_KO: begin
                    if (phase_cnt == 8'(KO_FRAMES - 1)) begin
                        phase_cnt <= '0;
                        if (match_won) rs <= R_MATCH_OVER;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                default: ;
            endcase

            if (enter_cd) begin
                rs          <= R_COUNTDOWN;
                phase_cnt   <= '0;
                player_rst  <= 1'b1;
                frames_left <= 13'(ROUND_FRAMES);
                winner      <= WIN_NONE;
                for (int i = 0; i < 2; i++) begin
                    health[i]    <= 3'(HEALTH_MAX);
                    block[i]     <= 3'(BLOCK_MAX);
                    regen_cnt[i] <= '0;
                    if (rs != R_KO) wins[i] <= '0;
                end
            end
        end
    end

    assign round_state = rs;
    assign p1_hit      = hit_out[0];
    assign p2_hit      = hit_out[1];
    assign p1_health   = health[0];
    assign p2_health   = health[1];
    assign p1_block    = block[0];
    assign p2_block    = block[1];
    assign p1_wins     = wins[0];
    assign p2_wins     = wins[1];

endmodule
